// File: rtl/button_event_decoder_pkg.sv
// Shared constants for the push-button front end.
// Holds the event-decoder state encoding and the default timing constants
// (in cycles of a 10 MHz clk) used by the debouncer and the event decoder.
package button_event_decoder_pkg;

    // Fixed 3-bit encoding; the display controller's debug view decodes these values.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    // Default timing at 10 MHz
    localparam int DEBOUNCE_TIME    = 200_000;     // 20 ms settle time in the debouncer
    localparam int LONG_TIME_DEF    = 10_000_000;  // 1 s hold classifies a long press
    localparam int GAP_TIME_DEF     = 3_000_000;   // 300 ms double-press window
    localparam int REPEAT_TIME_DEF  = 2_000_000;   // 200 ms auto-repeat period
    localparam int COUNTER_LEN_DEF  = 24;

endpackage

// File: rtl/button_event_decoder_btn_edge_detect.sv
// btn_edge_detect: registers a clean level and reports its rising/falling edges.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   level_i      - debounced level (1 = pressed)
//   rise_o       - level_i high while the registered copy is low (combinational)
//   fall_o       - level_i low while the registered copy is high (combinational)
// The delayed copy resets to 0, so a level already high at reset release
// shows up as a rise on the first edge.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level_i;
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into single-cycle
// short / double / long / repeat event pulses plus a "held" level.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   btn_level     - debounced button level, 1 = pressed
//   short_press   - pulse: press-release with no second press inside the gap
//   double_press  - pulse: second press released inside the gap window
//   long_press    - pulse: press held LONG_TIME cycles
//   repeat_pulse  - pulse every REPEAT_TIME cycles while still held after a long press
//   held          - level: high while in the long-press state
// All outputs are registered. Thresholds compare cnt >= T-1 so an event
// fires on the T-th edge after state entry; button edges beat timeouts.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_TIME   = LONG_TIME_DEF,
    parameter int GAP_TIME    = GAP_TIME_DEF,
    parameter int REPEAT_TIME = REPEAT_TIME_DEF,
    parameter int COUNTER_LEN = COUNTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [COUNTER_LEN-1:0] LONG_TH   = COUNTER_LEN'(LONG_TIME - 1);
    localparam logic [COUNTER_LEN-1:0] GAP_TH    = COUNTER_LEN'(GAP_TIME - 1);
    localparam logic [COUNTER_LEN-1:0] REPEAT_TH = COUNTER_LEN'(REPEAT_TIME - 1);
    localparam logic [COUNTER_LEN-1:0] CNT_ONE   = COUNTER_LEN'(1);

    logic rise, fall;

    btn_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .level_i (btn_level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e                 state_q, state_d;
    logic [COUNTER_LEN-1:0] cnt_q, cnt_d;
    logic short_q, short_d;
    logic double_q, double_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end
            ST_PRESS1: begin
                // A release on the threshold edge still counts as a short candidate.
                if (fall) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q >= LONG_TH) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q >= GAP_TH) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                // No long detection on the second press; counter stays put.
                if (fall) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= REPEAT_TH) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from next state so held lines up with long_press.
        held_d = (state_d == ST_LONG);
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with small timing parameters.
// Expected output vectors are queued per cycle when each scenario is driven;
// every cycle the full output vector is compared against the queue head
// (or all-zero when no entry is due).
module tb_button_event_decoder;

    localparam int LT = 8;
    localparam int GT = 4;
    localparam int RT = 3;

    // Output vector bit positions: {held, repeat, long, double, short}
    localparam logic [4:0] SH = 5'b00001;
    localparam logic [4:0] DB = 5'b00010;
    localparam logic [4:0] LG = 5'b00100;
    localparam logic [4:0] RP = 5'b01000;
    localparam logic [4:0] HD = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_level;
    logic short_press, double_press, long_press, repeat_pulse, held;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    button_event_decoder #(
        .LONG_TIME   (LT),
        .GAP_TIME    (GT),
        .REPEAT_TIME (RT),
        .COUNTER_LEN (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] outs();
        return {held, repeat_pulse, long_press, double_press, short_press};
    endfunction

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // Compare outputs for the cycle following edge 'cyc' (sampled on negedge),
    // then advance to just after the next posedge, where inputs are driven.
    task automatic tick();
        logic [4:0] obs, expv;
        @(negedge clk);
        obs  = outs();
        expv = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            expv = exp_q[0].v;
            void'(exp_q.pop_front());
        end
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL outputs cyc=%0d observed=%b expected=%b", cyc, obs, expv);
        end
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero(input string tag);
        logic [4:0] obs;
        obs = outs();
        n_checks++;
        assert (obs === 5'b0) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=00000", tag, obs);
        end
    endtask

    initial begin
        int e0, f0, f1;
        reset     = 1'b1;
        btn_level = 1'b0;
        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        @(posedge clk);
        #2;
        ticks(3);
        check_zero("reset_state");
        reset = 1'b0;
        ticks(3);
        check_zero("post_reset_idle");

        // Short press: 3 high, release -> short at F0+GT
        e0 = cyc + 1;
        f0 = e0 + 3;
        push(f0 + GT, SH);
        btn_level = 1'b1; ticks(3);
        btn_level = 1'b0; ticks(10);

        // Double press: high 2, low 2, high 2, low -> double on second release
        e0 = cyc + 1;
        f1 = e0 + 6;
        push(f1, DB);
        btn_level = 1'b1; ticks(2);
        btn_level = 1'b0; ticks(2);
        btn_level = 1'b1; ticks(2);
        btn_level = 1'b0; ticks(10);

        // Long press with repeat: hold 16 cycles
        e0 = cyc + 1;
        for (int k = LT; k < 16; k++) begin
            logic [4:0] v;
            v = HD;
            if (k == LT) v = v | LG;
            if (k > LT && (k - LT) % RT == 0) v = v | RP;
            push(e0 + k, v);
        end
        btn_level = 1'b1; ticks(16);
        btn_level = 1'b0; ticks(10);

        // Release sampled exactly on the long threshold edge -> short, not long
        e0 = cyc + 1;
        f0 = e0 + LT;
        push(f0 + GT, SH);
        btn_level = 1'b1; ticks(LT);
        btn_level = 1'b0; ticks(10);

        // Second press sampled exactly on the gap timeout edge -> double
        e0 = cyc + 1;
        f0 = e0 + 2;
        f1 = f0 + GT + 2;
        push(f1, DB);
        btn_level = 1'b1; ticks(2);
        btn_level = 1'b0; ticks(GT);
        btn_level = 1'b1; ticks(2);
        btn_level = 1'b0; ticks(10);

        // Reset mid-LONG with the button still high
        e0 = cyc + 1;
        push(e0 + LT, HD | LG);
        btn_level = 1'b1; ticks(LT + 2);
        reset = 1'b1;
        #1;
        check_zero("async_reset_clear");
        ticks(2);
        check_zero("reset_hold");
        reset = 1'b0;
        e0 = cyc + 1;
        push(e0 + LT, HD | LG);
        ticks(LT + 1);
        btn_level = 1'b0; ticks(10);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the clean, debounced push-button level into single-cycle user events: short press, double press, long press, and auto-repeat while held. It sits directly downstream of the button debouncer and upstream of the 7-segment display controller, which consumes the event pulses as mode and step commands. All timing is in clk cycles; the defaults assume a 10 MHz clk.

## Interface

Parameters:
- LONG_TIME, 10_000_000: hold duration, in cycles, that classifies a press as long (1 s).
- GAP_TIME, 3_000_000: maximum release-to-second-press gap, in cycles, for a double press (300 ms).
- REPEAT_TIME, 2_000_000: auto-repeat period, in cycles, while held after a long press (200 ms).
- COUNTER_LEN, 24: counter width. Must hold max(LONG_TIME, GAP_TIME, REPEAT_TIME) − 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- btn_level  in  1  debounced button level; 1 = pressed
- short_press  out  1  1-cycle pulse: single press-and-release with no second press in the gap
- double_press  out  1  1-cycle pulse: second press released within the double-press window
- long_press  out  1  1-cycle pulse: press held for LONG_TIME
- repeat_pulse  out  1  1-cycle pulse every REPEAT_TIME while still held after a long press
- held  out  1  level: high while in LONG

## Operation

- btn_q is a 1-cycle delayed copy of btn_level.
  - rise = btn_level & ~btn_q
  - fall = ~btn_level & btn_q
- cnt is a COUNTER_LEN-bit counter, cleared on every state entry. Thresholds are compared as cnt ≥ T−1, so an event fires at the T-th edge after entry.
- States use a 3-bit encoding: IDLE=0, PRESS1=1, GAP=2, PRESS2=3, LONG=4. Any unused encoding returns to IDLE with no pulse.
- IDLE:
  - rise → PRESS1.
- PRESS1:
  - fall → GAP.
  - else cnt ≥ LONG_TIME−1 → LONG, and long_press fires.
  - else cnt++.
- GAP:
  - rise → PRESS2.
  - else cnt ≥ GAP_TIME−1 → IDLE, and short_press fires.
  - else cnt++.
- PRESS2:
  - fall → IDLE, and double_press fires.
  - No long detection in this state; cnt is held.
- LONG:
  - fall → IDLE, with no pulse.
  - else cnt ≥ REPEAT_TIME−1 → repeat_pulse fires and cnt=0.
  - else cnt++.
- Priority: the edge (fall or rise) always beats the timeout in the same cycle.
  - Release on the LONG_TIME edge is a short/double candidate, not a long press.
  - A rise on the GAP_TIME edge enters PRESS2.
- At most one pulse output is high in any cycle.

## Timing

- All outputs are registered. Reset value of every output, btn_q, and cnt is 0; state resets to IDLE.
- Entry edge E0 is the first edge sampling btn_level=1 with btn_q=0.
- long_press is high for the cycle after edge E0+LONG_TIME.
- Repeat pulses follow after edges E0+LONG_TIME+k·REPEAT_TIME, for k ≥ 1.
- short_press is high after edge F0+GAP_TIME, where F0 is the edge sampling the release.
- double_press is high for the cycle after the second-release edge.
- held rises together with long_press and falls after the release edge. It carries no extra latency beyond the registered output.
- Reset mid-operation clears everything immediately (asynchronous); no pending event is emitted.
- btn_q resets to 0, so a button held across reset deassertion is detected as a new press on the first edge.

## Structure

- The shared package holds:
  - the state encoding constants
  - default timing constants for LONG_TIME, GAP_TIME and REPEAT_TIME at 10 MHz, shared with the debouncer's timing constant
- Sub-module btn_edge_detect holds the btn_q register and produces rise and fall. It is reused by the display controller for its mode input.
- The FSM, counter and output registers stay in button_event_decoder.

## Test plan

All scenarios use LONG_TIME=8, GAP_TIME=4, REPEAT_TIME=3, COUNTER_LEN=4.

- Short press: btn_level high 3 cycles, then low → short_press high exactly 1 cycle after edge F0+4; all other outputs stay 0.
- Double press: high 2, low 2, high 2, then low → one double_press after the second-release edge; no short_press.
- Long press with repeat: hold 16 cycles → long_press after E0+8; repeat_pulse after E0+11 and E0+14; held high from E0+8 until after the release edge; no pulse on release.
- Release exactly on the long threshold: release sampled at E0+8 → no long_press; short_press after F0+4.
- Second press exactly on the gap timeout: rise sampled at F0+4 → no short_press; double_press after the next release.
- Reset asserted mid-LONG with the button kept high: all outputs 0 immediately. After deassertion, the press is detected, with long_press 8 edges later.
